stim_sig_harness: RTL and testbench

Synthesisable stimulus-and-signature harness for differential checking of generated designs against their synthesised netlists. It drives a wide DUT input bus with a parametrised sequence of vectors, either LFSR-generated or streamed in over a ready/valid port. It periodically inserts all-zero glitch vectors and compacts the DUT output bus into a MISR signature. It sits beside `top` in simulation and on-chip builds, so comparing two netlists reduces to comparing two OUT_W-bit signatures instead of per-cycle `%b` dumps.

---
 rtl/stim_sig_harness.sv | 153 +++++++++++++++
 tb/tb_stim_sig_harness.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_sig_harness.sv
// Stimulus-and-signature harness: drives LFSR or streamed vectors (with periodic
// all-zero glitch slots) into a DUT and folds the DUT outputs into a MISR.
module stim_sig_harness #(
   parameter int IN_W       = 256,
   parameter int OUT_W      = 501,
   parameter int NUM_VEC    = 24,
   parameter int HOLD       = 1,
   parameter int ZERO_EVERY = 8,
   parameter int DUT_LAT    = 1,
   parameter logic [IN_W-1:0]  SEED      = IN_W'(1),
   parameter logic [IN_W-1:0]  TAPS      = IN_W'('hB8),
   parameter logic [OUT_W-1:0] MISR_TAPS = OUT_W'('h1D),
   localparam int CW = $clog2(NUM_VEC + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             mode,
   input  logic             vec_valid,
   input  logic [IN_W-1:0]  vec_data,
   output logic             vec_ready,
   output logic [IN_W-1:0]  stim,
   input  logic [OUT_W-1:0] y_in,
   output logic [OUT_W-1:0] signature,
   output logic [CW-1:0]    vec_count,
   output logic             busy,
   output logic             done,
   output logic [1:0]       fsm_state
);

   // Handshake: a vector transfers on a rising edge where vec_valid && vec_ready;
   // vec_ready is only offered at a free non-zero slot boundary in external mode.
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;

   state_t            state, state_nx;
   logic [IN_W-1:0]   lfsr;
   logic              mode_q;
   logic [HW-1:0]     hold_left;
   logic [CW-1:0]     since_zero;
   logic [DUT_LAT-1:0] tok;
   logic              slot_end, last_done, need_zero, begin_run;
   logic              launch, launch_zero;
   logic [IN_W-1:0]   launch_vec;

   function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] v);
      return (v >> 1) ^ (v[0] ? TAPS : '0);
   endfunction

   assign slot_end  = (hold_left == '0);
   assign last_done = (vec_count == CW'(NUM_VEC));
   assign need_zero = (ZERO_EVERY != 0) && (int'(since_zero) == ZERO_EVERY) && !last_done;
   assign begin_run = ((state == S_IDLE) || (state == S_DONE)) && start && !abort;

   assign vec_ready = (state == S_RUN) && mode_q && slot_end && !last_done && !need_zero;
   assign busy      = (state == S_RUN) || (state == S_DRAIN);
   assign done      = (state == S_DONE);
   assign fsm_state = state;

   always_comb begin
      state_nx    = state;
      launch      = 1'b0;
      launch_zero = 1'b0;
      launch_vec  = '0;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nx = S_RUN;
               if (!mode) begin
                  launch     = 1'b1;
                  launch_vec = SEED_EFF;
               end
            end
         end
         S_RUN: begin
            if (slot_end) begin
               if (last_done) begin
                  state_nx = S_DRAIN;
               end else if (need_zero) begin
                  launch      = 1'b1;
                  launch_zero = 1'b1;
               end else if (!mode_q) begin
                  launch     = 1'b1;
                  launch_vec = lfsr;
               end else if (vec_valid) begin
                  launch     = 1'b1;
                  launch_vec = vec_data;
               end
            end
         end
         S_DRAIN: if (tok == '0) state_nx = S_DONE;
         default: state_nx = S_IDLE;
      endcase
      if (abort) begin
         state_nx    = S_IDLE;
         launch      = 1'b0;
         launch_zero = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         stim       <= '0;
         signature  <= '0;
         vec_count  <= '0;
         lfsr       <= SEED_EFF;
         mode_q     <= 1'b0;
         hold_left  <= '0;
         since_zero <= '0;
         tok        <= '0;
      end else begin
         state <= state_nx;
         if (abort) begin
            tok  <= '0;
            stim <= '0;
         end else begin
            tok <= (tok << 1) | DUT_LAT'(launch);
            // A token leaving the pipeline means y_in now reflects that slot's vector.
            if (tok[DUT_LAT-1] && busy)
               signature <= {signature[OUT_W-2:0], 1'b0}
                            ^ (signature[OUT_W-1] ? MISR_TAPS : '0) ^ y_in;
            if (begin_run) begin
               signature  <= '0;
               vec_count  <= '0;
               since_zero <= '0;
               hold_left  <= '0;
               mode_q     <= mode;
               lfsr       <= mode ? SEED_EFF : lfsr_step(SEED_EFF);
            end else if (state == S_RUN && launch && !launch_zero && !mode_q) begin
               lfsr <= lfsr_step(lfsr);
            end
            if (launch) begin
               stim      <= launch_zero ? '0 : launch_vec;
               hold_left <= HW'(HOLD - 1);
               if (launch_zero) begin
                  since_zero <= '0;
               end else begin
                  vec_count  <= begin_run ? CW'(1) : vec_count + CW'(1);
                  since_zero <= begin_run ? CW'(1) : since_zero + CW'(1);
               end
            end else if (state == S_RUN && !slot_end) begin
               hold_left <= hold_left - HW'(1);
            end
            if (state == S_RUN && state_nx == S_DRAIN) stim <= '0;
         end
      end
   end

endmodule

// File: tb/tb_stim_sig_harness.sv
// Bench for stim_sig_harness: per-cycle comparison against a slot-level model,
// plus literal pins for LFSR order, zero insertion and MISR values.
module tb_stim_sig_harness;

   localparam int NV = 5;
   localparam int ZE = 2;
   localparam logic [7:0] SEED  = 8'h01;
   localparam logic [7:0] TAPS  = 8'hB8;
   localparam logic [7:0] MTAPS = 8'h1D;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0, mode = 1'b0, vec_valid = 1'b0;
   logic [7:0] vec_data = 8'h00;
   logic       vec_ready;
   logic [7:0] stim, y_in, signature;
   logic [2:0] vec_count;
   logic       busy, done;
   logic [1:0] fsm_state;
   logic       use_func = 1'b0;
   logic [7:0] y_const = 8'h00;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0] stim;
      logic [7:0] sig;
      logic [2:0] cnt;
      logic       busy;
      logic       done;
      logic       rdy;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       tr_q[$];
   exp_t       ce;
   int         cyc_idx = 0;
   logic [7:0] m_slots[$];
   logic [7:0] m_sig;
   int         m_drain, m_done;
   logic [7:0] clean0, clean1;
   logic [7:0] ext_vecs [5] = '{8'h3C, 8'h81, 8'h7E, 8'h42, 8'h99};
   logic [7:0] lit [7] = '{8'h01, 8'hB8, 8'h00, 8'h5C, 8'h2E, 8'h00, 8'h17};

   always #5 clk = ~clk;

   stim_sig_harness #(
      .IN_W(8), .OUT_W(8), .NUM_VEC(NV), .HOLD(1), .ZERO_EVERY(ZE), .DUT_LAT(1),
      .SEED(SEED), .TAPS(TAPS), .MISR_TAPS(MTAPS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
      .stim(stim), .y_in(y_in), .signature(signature), .vec_count(vec_count),
      .busy(busy), .done(done), .fsm_state(fsm_state)
   );

   // Stand-in DUT: combinational, so its output for a slot is ready one edge later.
   function automatic logic [7:0] dut_f(input logic [7:0] s);
      return {s[6:0], s[7]} ^ 8'hA5;
   endfunction

   assign y_in = use_func ? dut_f(stim) : y_const;

   function automatic logic [7:0] model_y(input logic [7:0] s);
      return use_func ? dut_f(s) : y_const;
   endfunction

   function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] y);
      return {s[6:0], 1'b0} ^ (s[7] ? MTAPS : 8'h00) ^ y;
   endfunction

   function automatic bit valid_at(input int c, input int st);
      return !(st >= 0 && c >= st && c < st + 3);
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Slot list first (vectors with zero slots interleaved), then a per-edge timeline.
   task automatic build(input bit m1, input int st, input int ab);
      logic [7:0] v[$];
      logic [7:0] l, cur, sig;
      int   s, cnt, phase, tail;
      bit   launched, prev_l, aborted;
      exp_t e;
      v = {};
      l = SEED;
      for (int i = 0; i < NV; i++) begin
         if (m1) v.push_back(ext_vecs[i]);
         else begin
            v.push_back(l);
            l = (l >> 1) ^ (l[0] ? TAPS : 8'h00);
         end
      end
      m_slots = {};
      for (int i = 0; i < NV; i++) begin
         m_slots.push_back(v[i]);
         if ((i + 1) % ZE == 0 && i + 1 < NV) m_slots.push_back(8'h00);
      end
      tr_q = {};
      s = 0; cnt = 0; cur = 8'h00; sig = 8'h00; prev_l = 0; phase = 0;
      aborted = 0; tail = 0; m_drain = -1; m_done = -1;
      for (int j = 0; j < 60 && tail < 3; j++) begin
         launched = 0;
         if (aborted || (ab >= 0 && j == ab + 1)) begin
            aborted = 1; cur = 8'h00; phase = 3; tail++;
         end else begin
            if (prev_l) sig = misr(sig, model_y(cur));
            if (phase == 0) begin
               if (s == m_slots.size()) begin
                  phase = 1; cur = 8'h00; m_drain = j;
               end else if (!m1 || (j > 0 && (m_slots[s] == 8'h00 || valid_at(j - 1, st)))) begin
                  cur = m_slots[s];
                  if (cur != 8'h00) cnt++;
                  s++;
                  launched = 1;
               end
            end else if (phase == 1) begin
               phase = 2; m_done = j;
            end
            if (phase == 2) tail++;
         end
         prev_l = launched;
         e.stim = cur;
         e.sig  = sig;
         e.cnt  = 3'(cnt);
         e.busy = (phase == 0 || phase == 1);
         e.done = (phase == 2);
         e.rdy  = (phase == 0 && m1 && s < m_slots.size() && m_slots[s] != 8'h00);
         tr_q.push_back(e);
      end
      m_sig = sig;
   endtask

   task automatic run(input bit m1, input int st, input int ab, input bit rst_in_drain);
      int   n, idx;
      bit   hs;
      exp_t dropped;
      build(m1, st, ab);
      if (rst_in_drain) while (tr_q.size() > m_drain + 1) dropped = tr_q.pop_back();
      n = tr_q.size();
      idx = 0;
      @(posedge clk); #1;
      start = 1'b1; mode = m1; vec_valid = 1'b0; abort = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      cyc_idx = 0;
      exp_q = tr_q;
      for (int c = 0; c < n; c++) begin
         abort     = (c == ab);
         vec_valid = m1 && idx < NV && valid_at(c, st);
         vec_data  = (idx < NV) ? ext_vecs[idx] : 8'h00;
         @(negedge clk);
         hs = vec_valid && vec_ready;
         if (rst_in_drain && c == n - 1) begin
            #1 rst_n = 1'b0;
            #1;
            chk("rst_stim", c, 32'(stim), 32'h0);
            chk("rst_sig", c, 32'(signature), 32'h0);
            chk("rst_cnt", c, 32'(vec_count), 32'h0);
            chk("rst_busy", c, 32'(busy), 32'h0);
            chk("rst_done", c, 32'(done), 32'h0);
            chk("rst_rdy", c, 32'(vec_ready), 32'h0);
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            @(posedge clk); #1;
            if (hs) idx++;
         end
      end
      abort = 1'b0;
      vec_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         ce = exp_q.pop_front();
         chk("stim", cyc_idx, 32'(stim), 32'(ce.stim));
         chk("sig", cyc_idx, 32'(signature), 32'(ce.sig));
         chk("cnt", cyc_idx, 32'(vec_count), 32'(ce.cnt));
         chk("busy", cyc_idx, 32'(busy), 32'(ce.busy));
         chk("done", cyc_idx, 32'(done), 32'(ce.done));
         chk("rdy", cyc_idx, 32'(vec_ready), 32'(ce.rdy));
         cyc_idx++;
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("init_stim", -1, 32'(stim), 32'h0);
      chk("init_sig", -1, 32'(signature), 32'h0);
      chk("init_cnt", -1, 32'(vec_count), 32'h0);
      chk("init_busy", -1, 32'(busy), 32'h0);
      chk("init_done", -1, 32'(done), 32'h0);
      chk("init_rdy", -1, 32'(vec_ready), 32'h0);
      rst_n = 1'b1;

      use_func = 1'b0; y_const = 8'h01;
      run(0, -1, -1, 0);
      chk("slot_n", -1, 32'(m_slots.size()), 32'd7);
      for (int i = 0; i < 7; i++) chk("slot_lit", i, 32'(m_slots[i]), 32'(lit[i]));
      chk("model_sig1", 1, 32'(tr_q[1].sig), 32'h01);
      chk("model_sig2", 2, 32'(tr_q[2].sig), 32'h03);
      chk("model_done_at", -1, 32'(m_done), 32'd8);
      chk("sig_const1", -1, 32'(signature), 32'h7F);
      chk("cnt_end", -1, 32'(vec_count), 32'd5);
      chk("done_end", -1, 32'(done), 32'd1);

      y_const = 8'h00;
      run(0, -1, -1, 0);
      chk("sig_zero", -1, 32'(signature), 32'h00);

      use_func = 1'b1;
      run(0, -1, -1, 0);
      clean0 = m_sig;
      run(1, -1, -1, 0);
      clean1 = m_sig;
      run(1, 4, -1, 0);
      chk("stall_sig", -1, 32'(signature), 32'(clean1));

      run(0, -1, 3, 0);
      chk("abort_done", -1, 32'(done), 32'd0);
      run(0, -1, -1, 0);
      chk("restart_sig", -1, 32'(signature), 32'(clean0));

      run(0, -1, -1, 1);
      run(0, -1, -1, 0);
      chk("post_reset_sig", -1, 32'(signature), 32'(clean0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
